// File: rtl/cnt_pkg.sv
`default_nettype none
// cnt_pkg: shared state encoding and default width for the cnt_down_3bit counter.
package cnt_pkg;
  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/d_ff_ar.sv
`default_nettype none
// d_ff_ar: WIDTH-bit D register, asynchronous active-low reset to zero.
module d_ff_ar
  import cnt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end
endmodule
`default_nettype wire

// File: rtl/cnt_down_3bit.sv
`default_nettype none
// cnt_down_3bit: loadable down counter with borrow pulse and IDLE/RUN/DONE control.
// Define CNT_DOWN_RELOAD_EN for auto-reload from rld instead of stopping in DONE.
module cnt_down_3bit
  import cnt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             bo,
  output logic             busy
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rld, q_nxt, rld_nxt;
  logic             bo_nxt;

  d_ff_ar #(.WIDTH(WIDTH)) u_q_reg (
    .clk(clk), .rst_n(rst_n), .d(q_nxt), .q(q)
  );

  d_ff_ar #(.WIDTH(WIDTH)) u_rld_reg (
    .clk(clk), .rst_n(rst_n), .d(rld_nxt), .q(rld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bo    <= 1'b0;
    end else begin
      state <= state_nxt;
      bo    <= bo_nxt;
    end
  end

  always_comb begin
    q_nxt     = q;
    rld_nxt   = rld;
    state_nxt = state;
    bo_nxt    = 1'b0;
    if (load) begin
      q_nxt     = din;
      rld_nxt   = din;
      state_nxt = (din != '0) ? RUN : DONE;
    end else if (start && state != RUN) begin
      q_nxt     = rld;
      state_nxt = (rld != '0) ? RUN : DONE;
    end else if (state == RUN && en) begin
      if (q > ONE) begin
        q_nxt = q - ONE;
      end else if (q == ONE) begin
        q_nxt  = '0;
        bo_nxt = 1'b1;
`ifdef CNT_DOWN_RELOAD_EN
        state_nxt = RUN;
`else
        state_nxt = DONE;
`endif
      end else begin
        // q == 0 while running only occurs after an auto-reload borrow
`ifdef CNT_DOWN_RELOAD_EN
        q_nxt = rld;
`else
        state_nxt = DONE;
`endif
      end
    end
  end

  assign busy = (state == RUN);
  assign zero = (q == '0);
endmodule
`default_nettype wire

// File: tb/tb_cnt_down_3bit.sv
`default_nettype none
// tb_cnt_down_3bit: directed and randomized checks against a behavioural countdown model.
module tb_cnt_down_3bit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0, start = 1'b0, en = 1'b0;
  logic [2:0] din = 3'd0;
  logic [2:0] q;
  logic       zero, bo, busy;

  int checks = 0;
  int errors = 0;

  // model: current value, value to restart from, whether a countdown is active, borrow
  logic [2:0] m_q = 3'd0, m_rld = 3'd0;
  bit         m_run = 1'b0, m_bo = 1'b0;

  cnt_down_3bit #(.WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .din(din), .start(start),
    .en(en), .q(q), .zero(zero), .bo(bo), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_q = 3'd0; m_rld = 3'd0; m_run = 1'b0; m_bo = 1'b0;
  endfunction

  function automatic void model_step(input bit l, input bit s, input bit e, input logic [2:0] d);
    int v;
    m_bo = 1'b0;
    if (l) begin
      m_q = d; m_rld = d; m_run = (d != 0);
    end else if (s && !m_run) begin
      m_q = m_rld; m_run = (m_rld != 0);
    end else if (m_run && e) begin
      v = int'(m_q);
`ifdef CNT_DOWN_RELOAD_EN
      if (v == 0) v = int'(m_rld);
      else begin
        v = v - 1;
        if (v == 0) m_bo = 1'b1;
      end
`else
      v = v - 1;
      if (v == 0) begin m_bo = 1'b1; m_run = 1'b0; end
`endif
      m_q = 3'(v);
    end
  endfunction

  task automatic cycle(input bit l, input bit s, input bit e, input logic [2:0] d);
    load = l; start = s; en = e; din = d;
    model_step(l, s, e, d);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 3'd0);
      checks++;
      if ({q, zero, bo, busy} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: q=%0d zero=%b bo=%b busy=%b, want q=0 zero=1 bo=0 busy=0",
                 i, q, zero, bo, busy);
      end
    end
  endtask

`ifndef CNT_DOWN_RELOAD_EN
  task automatic test_countdown();
    int eq[8] = '{5, 4, 3, 2, 1, 0, 0, 0};
    cycle(1, 0, 1, 3'd5);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cycle(0, 0, 1, 3'd0);
      checks++;
      if ({q, zero, bo, busy} !== {3'(eq[i]), eq[i] == 0, i == 5, i < 5}) begin
        errors++;
        $display("FAIL countdown5 step %0d: q=%0d zero=%b bo=%b busy=%b, want q=%0d zero=%b bo=%b busy=%b",
                 i, q, zero, bo, busy, eq[i], eq[i] == 0, i == 5, i < 5);
      end
    end
  endtask

  task automatic test_en_toggle();
    int  eq[6] = '{3, 2, 2, 2, 1, 0};
    bit  ens[6] = '{1, 1, 0, 0, 1, 1};
    int  pulses = 0;
    cycle(1, 0, 1, 3'd3);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cycle(0, 0, ens[i], 3'd0);
      if (bo) pulses++;
      checks++;
      if (q !== 3'(eq[i])) begin
        errors++;
        $display("FAIL en_toggle step %0d: q=%0d want %0d", i, q, eq[i]);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL en_toggle_bo_count: got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_start();
    cycle(0, 1, 0, 3'd0);   // DONE with rld = 3
    checks++;
    if ({q, busy} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL start_from_done: q=%0d busy=%b want q=3 busy=1", q, busy);
    end
    cycle(0, 1, 1, 3'd0);   // start in RUN must not restart
    checks++;
    if (q !== 3'd2) begin
      errors++;
      $display("FAIL start_in_run: q=%0d want 2", q);
    end
    cycle(1, 1, 0, 3'd6);
    checks++;
    if ({q, busy} !== {3'd6, 1'b1}) begin
      errors++;
      $display("FAIL load_beats_start: q=%0d busy=%b want q=6 busy=1", q, busy);
    end
  endtask

  task automatic test_load_zero();
    cycle(1, 0, 1, 3'd0);
    checks++;
    if ({q, zero, bo, busy} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_zero: q=%0d zero=%b bo=%b busy=%b want q=0 zero=1 bo=0 busy=0", q, zero, bo, busy);
    end
    cycle(0, 1, 1, 3'd0);
    checks++;
    if ({q, zero, busy} !== {3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL start_rld_zero: q=%0d zero=%b busy=%b want q=0 zero=1 busy=0", q, zero, busy);
    end
  endtask
`else
  task automatic test_reload();
    cycle(1, 0, 1, 3'd2);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cycle(0, 0, 1, 3'd0);
      checks++;
      if ({q, bo, busy} !== {3'(2 - (i % 3)), (i % 3) == 2, 1'b1}) begin
        errors++;
        $display("FAIL reload step %0d: q=%0d bo=%b busy=%b want q=%0d bo=%b busy=1",
                 i, q, bo, busy, 2 - (i % 3), (i % 3) == 2);
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    cycle(1, 0, 1, 3'd1);
    cycle(0, 0, 1, 3'd0);
    checks++;
    if ({q, bo} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_borrow: q=%0d bo=%b want q=0 bo=1", q, bo);
    end
    cycle(1, 0, 1, 3'd4);
    checks++;
    if ({q, bo, busy} !== {3'd4, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_load_on_bo: q=%0d bo=%b busy=%b want q=4 bo=0 busy=1", q, bo, busy);
    end
  endtask

  task automatic test_random();
    bit l, s, e;
    for (int i = 0; i < 400; i++) begin
      l = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 5) == 0);
      e = ($urandom_range(0, 3) != 0);
      cycle(l, s, e, 3'($urandom_range(0, 7)));
      checks++;
      if ({q, zero, bo, busy} !== {m_q, m_q == 3'd0, m_bo, m_run}) begin
        errors++;
        $display("FAIL random cyc %0d: q=%0d zero=%b bo=%b busy=%b want q=%0d zero=%b bo=%b busy=%b",
                 i, q, zero, bo, busy, m_q, m_q == 3'd0, m_bo, m_run);
      end
    end
  endtask

  task automatic test_reset_midcount();
    cycle(1, 0, 1, 3'd5);
    cycle(0, 0, 1, 3'd0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({q, zero, bo, busy} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: q=%0d zero=%b bo=%b busy=%b want q=0 zero=1 bo=0 busy=0", q, zero, bo, busy);
    end
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 3'd0);
      checks++;
      if ({q, busy} !== {3'd0, 1'b0}) begin
        errors++;
        $display("FAIL post_reset_idle cyc %0d: q=%0d busy=%b want q=0 busy=0", i, q, busy);
      end
    end
  endtask

  initial begin
    test_reset();
`ifndef CNT_DOWN_RELOAD_EN
    test_countdown();
    test_en_toggle();
    test_start();
    test_load_zero();
`else
    test_reload();
`endif
    test_back_to_back();
    test_random();
    test_reset_midcount();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cnt_down_3bit.md
# cnt_down_3bit

Synchronous, loadable 3-bit down counter with a borrow pulse and a small run/done controller. It is the count-down counterpart of the ripple up-counter used in the nixie-tube digit path. It drives countdown digits and timers, and cascades through its borrow pulse. Every flop is clocked by the single system clock; there is no ripple clocking.

## Interface
Parameters:
- WIDTH, 3, counter width in bits; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- load  input  1  load din into the counter and the reload register; highest priority
- din  input  WIDTH  load value
- start  input  1  restart from the reload register; honoured only in IDLE or DONE
- en  input  1  count enable; one decrement per clk in RUN while high
- q  output  WIDTH  current count (registered)
- zero  output  1  high when q == 0
- bo  output  1  borrow pulse, one clk wide
- busy  output  1  high in RUN

## Operation
- FSM states:
  - IDLE: after reset only.
  - RUN: counting.
  - DONE: terminal count reached.
- Registers: q, rld (reload value, WIDTH bits), state, bo.
- Priority per clk: load > start > count.
- load, in any state:
  - q <= din and rld <= din.
  - If din != 0, next state is RUN; otherwise next state is DONE.
  - bo stays 0.
- start, in IDLE or DONE, with no load:
  - q <= rld.
  - If rld != 0, next state is RUN; otherwise next state is DONE.
  - start is ignored in RUN.
- RUN with en = 1:
  - q > 1: q <= q - 1.
  - q == 1: q <= 0 and bo <= 1 for exactly one clk. Next state is DONE; with CNT_DOWN_RELOAD_EN, see Configuration.
- RUN with en = 0: q holds and bo <= 0.
- DONE: q holds at 0 and en is ignored.
- busy = (state == RUN). zero = (q == 0), decoded from registered q only.
- Reset values: q = 0, rld = 0, state = IDLE, bo = 0, zero = 1, busy = 0.

## Timing
- Load latency: q shows din in the clk after the load edge. busy rises the same cycle.
- Count: q changes one clk after each edge that samples en = 1.
- From load of N (N != 0) with en held high:
  - q reads N, N-1, …, 1, 0 on consecutive cycles.
  - bo is high in the cycle q first reads 0. busy falls in that same cycle.
- Load while bo is high: bo is low next cycle and q = din.
- Simultaneous load and start: load wins and start is dropped.
- Reset asserted mid-count: all outputs return to reset values asynchronously. After release, the block stays in IDLE until load or start.

## Configuration
- CNT_DOWN_RELOAD_EN defined (auto-reload):
  - At q == 1 with en = 1, q <= 0 and bo pulses, but the state stays RUN.
  - On the next en = 1 cycle at q == 0, q <= rld. The period is rld + 1 enabled cycles.
  - If rld == 0 (only reachable via load of 0, which enters DONE), behaviour is unchanged.
  - DONE is reached only via load or start of 0.
- CNT_DOWN_RELOAD_EN undefined: one-shot countdown that stops in DONE. Only load or start leaves DONE.

## Structure
- Shared package cnt_pkg holds:
  - State enum: IDLE, RUN, DONE.
  - Default WIDTH constant: 3.
- The counter datapath and FSM are one module.
- One sub-module, d_ff_ar: a WIDTH-parameterised D register with asynchronous active-low reset. It is instantiated for q and for rld.

## Test plan
- Reset, then no stimulus: q = 0, zero = 1, busy = 0, bo = 0 for 10 cycles.
- load din = 5, en held 1: q reads 5, 4, 3, 2, 1, 0. bo is high only on the q = 0 cycle, busy falls with it, and q stays 0 thereafter (macro undefined).
- load 3 with en toggling 1, 0, 0, 1, 1: q reads 3, 2, 2, 2, 1, 0. Exactly one bo pulse.
- After DONE, pulse start: q = 3 next cycle and busy = 1. start asserted during RUN has no effect. load and start together with din = 6 gives q = 6.
- load 0: state DONE, zero = 1, bo = 0. start with rld = 0 stays in DONE.
- With CNT_DOWN_RELOAD_EN, load 2 and en held: q reads 2, 1, 0, 2, 1, 0, … with bo every third cycle. rst_n asserted mid-sequence forces q = 0 immediately.
